// File: rtl/switch_pkg.sv
// Shared constants, loopback-strip helper and packet classification for the
// N-port round-robin switch.
package switch_pkg;

   localparam int N_PORTS_DEF = 4;
   localparam int DATA_W_DEF  = 8;
   localparam int MAX_PORTS   = 8;

   // Single-destination, multi-destination, broadcast
   typedef enum logic [1:0] {
      SDP = 2'd0,
      MDP = 2'd1,
      BDP = 2'd2
   } pkt_type_e;

   // Clears the bit of the ingress port so a packet never returns to its source
   function automatic logic [MAX_PORTS-1:0] strip_loopback(
      input logic [MAX_PORTS-1:0] mask,
      input logic [2:0]           port
   );
      return mask & ~(8'd1 << port);
   endfunction

endpackage

// File: rtl/switch_rr_arbiter.sv
// Rotating-priority arbiter: the first requester after ptr (wrapping) wins.
module switch_rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt
);

   // Scan requesters starting just after the last winner; first hit is granted
   always_comb begin : p_scan
      logic found_s;
      int   idx_s;
      gnt     = {N{1'b0}};
      found_s = 1'b0;
      idx_s   = 0;
      for (int k = 1; k <= N; k++) begin
         idx_s      = (int'(ptr) + k) % N;
         gnt[idx_s] = req[idx_s] & ~found_s;
         found_s    = found_s | req[idx_s];
      end
   end

endmodule

// File: rtl/switch_nport_rr.sv
// N-port packet switch: per-ingress FIFOs, per-egress round-robin arbitration,
// multicast with partial service, loopback stripping and a drop counter.
module switch_nport_rr
   import switch_pkg::*;
#(
   parameter int N_PORTS = N_PORTS_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 16,
   parameter int SRC_W   = $clog2(N_PORTS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_PORTS-1:0]          valid_in,
   input  logic [N_PORTS*SRC_W-1:0]    source_in,
   input  logic [N_PORTS*N_PORTS-1:0]  target_in,
   input  logic [N_PORTS*DATA_W-1:0]   data_in,
   output logic [N_PORTS-1:0]          ready_out,
   output logic [N_PORTS-1:0]          valid_out,
   output logic [N_PORTS*SRC_W-1:0]    source_out,
   output logic [N_PORTS*DATA_W-1:0]   data_out,
   output logic [CNT_W-1:0]            drop_cnt
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int SUM_W = CNT_W + 4;

   typedef struct packed {
      logic [SRC_W-1:0]   src;
      logic [N_PORTS-1:0] mask;
      logic [DATA_W-1:0]  data;
   } pkt_t;

   pkt_t               fifo_r    [N_PORTS][DEPTH];
   logic [AW-1:0]      wr_ptr_r  [N_PORTS];
   logic [AW-1:0]      rd_ptr_r  [N_PORTS];
   logic [CW-1:0]      cnt_r     [N_PORTS];
   logic [CW-1:0]      cnt_nxt_s [N_PORTS];
   logic [N_PORTS-1:0] served_r  [N_PORTS];   // per input: outputs already served for head
   logic [N_PORTS-1:0] mask_s    [N_PORTS];   // per input: loopback-stripped target
   pkt_t               head_s    [N_PORTS];
   logic [N_PORTS-1:0] rem_s     [N_PORTS];   // per input: outputs still owed by head
   logic [N_PORTS-1:0] req_s     [N_PORTS];   // per output: requesting inputs
   logic [N_PORTS-1:0] gnt_s     [N_PORTS];   // per output: one-hot granted input
   logic [N_PORTS-1:0] hit_s     [N_PORTS];   // per input: outputs granting it now
   logic [SRC_W-1:0]   ptr_r     [N_PORTS];
   logic [SRC_W-1:0]   gidx_s    [N_PORTS];
   logic [N_PORTS-1:0] any_gnt_s;
   logic [N_PORTS-1:0] push_s;
   logic [N_PORTS-1:0] pop_s;
   logic [N_PORTS-1:0] drop_s;
   logic [3:0]         ndrop_s;
   logic [SUM_W-1:0]   sum_s;
   logic [CNT_W-1:0]   drop_nxt_s;

   // Strip the loopback bit and decide between enqueue and drop per ingress
   always_comb begin
      for (int p = 0; p < N_PORTS; p++) begin
         mask_s[p] = N_PORTS'(strip_loopback(MAX_PORTS'(target_in[p*N_PORTS +: N_PORTS]), 3'(p)));
         push_s[p] = valid_in[p] & ready_out[p] & (|mask_s[p]);
         drop_s[p] = valid_in[p] & ~push_s[p];
      end
   end

   // Expose each FIFO head and the destinations it still has to reach
   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         head_s[i] = fifo_r[i][rd_ptr_r[i]];
         if (cnt_r[i] != {CW{1'b0}}) begin
            rem_s[i] = head_s[i].mask & ~served_r[i];
         end else begin
            rem_s[i] = {N_PORTS{1'b0}};
         end
      end
   end

   // Transpose head demands into per-output request vectors
   always_comb begin
      for (int o = 0; o < N_PORTS; o++) begin
         for (int i = 0; i < N_PORTS; i++) begin
            req_s[o][i] = rem_s[i][o];
         end
      end
   end

   for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
      switch_rr_arbiter #(.N(N_PORTS)) u_arb (
         .req (req_s[o]),
         .ptr (ptr_r[o]),
         .gnt (gnt_s[o])
      );
   end

   // Transpose grants back per input and encode the winner of each output
   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         for (int o = 0; o < N_PORTS; o++) begin
            hit_s[i][o] = gnt_s[o][i];
         end
      end
      for (int o = 0; o < N_PORTS; o++) begin
         any_gnt_s[o] = |gnt_s[o];
         gidx_s[o]    = {SRC_W{1'b0}};
         for (int i = 0; i < N_PORTS; i++) begin
            gidx_s[o] = gidx_s[o] | (gnt_s[o][i] ? SRC_W'(i) : {SRC_W{1'b0}});
         end
      end
   end

   // Head retires once the grants of this cycle cover every remaining target
   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         pop_s[i]     = (|hit_s[i]) & ~(|(rem_s[i] & ~hit_s[i]));
         cnt_nxt_s[i] = cnt_r[i] + {{AW{1'b0}}, push_s[i]} - {{AW{1'b0}}, pop_s[i]};
      end
   end

   // FIFO pointers, occupancy, head service tracking and registered ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_PORTS; i++) begin
            wr_ptr_r[i] <= {AW{1'b0}};
            rd_ptr_r[i] <= {AW{1'b0}};
            cnt_r[i]    <= {CW{1'b0}};
            served_r[i] <= {N_PORTS{1'b0}};
         end
         ready_out <= {N_PORTS{1'b1}};
      end else begin
         for (int i = 0; i < N_PORTS; i++) begin
            if (push_s[i]) begin
               wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
            end
            if (pop_s[i]) begin
               rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
               served_r[i] <= {N_PORTS{1'b0}};
            end else begin
               served_r[i] <= served_r[i] | hit_s[i];
            end
            cnt_r[i]     <= cnt_nxt_s[i];
            ready_out[i] <= (cnt_nxt_s[i] != CW'(DEPTH));
         end
      end
   end

   // FIFO storage, written at the tail on every accepted packet
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_PORTS; i++) begin
         if (push_s[i]) begin
            fifo_r[i][wr_ptr_r[i]] <= '{src:  source_in[i*SRC_W +: SRC_W],
                                        mask: mask_s[i],
                                        data: data_in[i*DATA_W +: DATA_W]};
         end
      end
   end

   // Egress registers and round-robin pointers; idle outputs return to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out  <= {N_PORTS{1'b0}};
         source_out <= {(N_PORTS*SRC_W){1'b0}};
         data_out   <= {(N_PORTS*DATA_W){1'b0}};
         for (int o = 0; o < N_PORTS; o++) begin
            ptr_r[o] <= SRC_W'(N_PORTS - 1);
         end
      end else begin
         for (int o = 0; o < N_PORTS; o++) begin
            valid_out[o] <= any_gnt_s[o];
            if (any_gnt_s[o]) begin
               source_out[o*SRC_W +: SRC_W]  <= head_s[gidx_s[o]].src;
               data_out[o*DATA_W +: DATA_W]  <= head_s[gidx_s[o]].data;
               ptr_r[o]                      <= gidx_s[o];
            end else begin
               source_out[o*SRC_W +: SRC_W]  <= {SRC_W{1'b0}};
               data_out[o*DATA_W +: DATA_W]  <= {DATA_W{1'b0}};
            end
         end
      end
   end

   // Sum this cycle's drops and saturate at all-ones
   always_comb begin
      ndrop_s = 4'd0;
      for (int p = 0; p < N_PORTS; p++) begin
         ndrop_s = ndrop_s + {3'd0, drop_s[p]};
      end
      sum_s = {4'd0, drop_cnt} + {{CNT_W{1'b0}}, ndrop_s};
      if (sum_s > {4'd0, {CNT_W{1'b1}}}) begin
         drop_nxt_s = {CNT_W{1'b1}};
      end else begin
         drop_nxt_s = sum_s[CNT_W-1:0];
      end
   end

   // Drop counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= {CNT_W{1'b0}};
      end else begin
         drop_cnt <= drop_nxt_s;
      end
   end

endmodule
